taglist_builder: RTL
====================

# taglist_builder

Parametrised tag-list generator that scans a stream of per-position end codes from the sequence ROM reader and writes one descriptor per sequence into the tag-list RAM. Each descriptor holds sequence number, first position, last position and an end-of-ROM flag. It extends the original tag-list generator with generic widths, a RAM write handshake, a symbol ready/valid handshake, a table-full/position-wrap error report and restart without reset.

## Interface
- ADDR_W, 10, width of the scan position and of the first/last fields
- SEQ_W, 7, width of sequence number and RAM address
- RAM_W, 32, descriptor width; must be >= SEQ_W+2*ADDR_W+1
- MAX_ENTRIES, 2**SEQ_W, descriptor capacity (1..2**SEQ_W)
- clk_1KHz  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a scan; honoured only in IDLE or DONE
- sym_valid  in  1  sym_code is presented
- sym_code  in  2  00 interior element, 10 last element of sequence, 11 last element of ROM, 01 reserved
- sym_ready  out  1  block accepts a symbol this cycle (high only in SCAN)
- ram_we  out  1  descriptor write request
- ram_ready  in  1  RAM accepts the write when ram_we & ram_ready
- ram_addr  out  SEQ_W  descriptor index (= sequence number)
- ram_data  out  RAM_W  descriptor
- entry_count  out  SEQ_W+1  descriptors written this scan
- pos  out  ADDR_W  current scan position
- busy  out  1  state is SCAN or WRITE
- done  out  1  scan finished, held until start or reset
- err  out  2  sticky: bit0 table full (descriptor dropped), bit1 position wrapped

## Operation
- States: IDLE, SCAN, WRITE, DONE. Reset goes to IDLE.
- IDLE/DONE + start: pos, first, seq, entry_count, err and done all clear. Next state is SCAN.
- SCAN: a symbol is accepted on sym_valid & sym_ready. The accepted symbol occupies position pos.
  - 00 or 01: pos <= pos+1. Code 01 is treated as 00.
  - 10: latch descriptor {seq, first, last=pos, flag=0}. Then pos <= pos+1 and first <= pos+1. Go to WRITE.
  - 11: latch descriptor {seq, first, last=pos, flag=1}. Go to WRITE. After that write, go to DONE, not SCAN.
- Descriptor layout:
  - [0] flag
  - [ADDR_W:1] last
  - [2*ADDR_W:ADDR_W+1] first
  - [SEQ_W+2*ADDR_W:2*ADDR_W+1] seq
  - remaining upper bits 0
- WRITE: ram_we=1, ram_addr=seq, ram_data=latched descriptor. All three are held stable until ram_ready.
  - On acceptance: seq++ and entry_count++. Go to SCAN, or to DONE for an end-of-ROM descriptor.
- Table full: an end code arriving when entry_count == MAX_ENTRIES:
  - no WRITE; err[0] <= 1; pos/first still advance.
  - Code 10 stays in SCAN. Code 11 goes directly to DONE.
- Position wrap: accepting any symbol at pos == 2**ADDR_W-1 sets err[1] and wraps pos to 0. first wraps the same way.
- start while busy is ignored. sym_valid outside SCAN is ignored and no symbol is consumed.
- Arithmetic is unsigned modulo field width. seq increments only on accepted writes.

## Timing
- Reset values: state IDLE. sym_ready, ram_we, busy, done = 0. ram_addr, ram_data, entry_count, pos, err = 0.
- Reset mid-WRITE drops the pending write: ram_we is 0 from the next edge and no RAM write occurs.
- start sampled at edge N: SCAN (sym_ready=1) from N+1.
- End symbol accepted at edge N: ram_we=1 from N+1. With ram_ready=1 the write completes at edge N+1 and sym_ready=1 again from N+2.
- Throughput: 1 symbol/cycle for interior codes, 2 cycles minimum per end code.
- done rises on the edge that accepts the end-of-ROM write, or the edge that accepts code 11 when the table is full.
- Outputs are registered. sym_ready and busy decode the registered state.

## Test plan
- Defaults, ram_ready=1, codes 00,00,10,00,11 -> two writes:
  - addr0 data 0x00000004 (seq0, first0, last2)
  - addr1 data 0x00201809 (seq1, first3, last4, flag1)
  - then done=1, entry_count=2, err=0
- Same stream with ram_ready low for 3 cycles on the first write -> ram_we, ram_addr, ram_data stable for 4 cycles; sym_ready=0; no symbol lost; results identical.
- Codes 10,10,11 -> descriptors (seq, first, last, flag) = (0,0,0,0), (1,1,1,0), (2,2,2,1); done=1.
- MAX_ENTRIES=4, five 10 codes then 11 -> 4 writes (addr 0..3), err=01, done=1, entry_count=4.
- ADDR_W=3, nine 00 then 10 -> err[1]=1; descriptor first=0, last=1 (pos wrapped); seq=0.
- reset asserted while ram_we=1 -> ram_we=0 next cycle and all outputs are at reset values. A subsequent start plus the stream 10,11 rescans from pos 0.

Source files
------------

// File: rtl/taglist_builder.sv
// taglist_builder: scans per-position end codes from the sequence ROM reader
// and writes one {seq, first, last, end-of-ROM} descriptor per sequence into
// the tag-list RAM through a we/ready handshake.
module taglist_builder #(
  parameter int ADDR_W      = 10,
  parameter int SEQ_W       = 7,
  parameter int RAM_W       = 32,
  parameter int MAX_ENTRIES = 2**SEQ_W
) (
  input  logic              clk_1KHz,
  input  logic              reset,
  input  logic              start,
  input  logic              sym_valid,
  input  logic [1:0]        sym_code,
  output logic              sym_ready,
  output logic              ram_we,
  input  logic              ram_ready,
  output logic [SEQ_W-1:0]  ram_addr,
  output logic [RAM_W-1:0]  ram_data,
  output logic [SEQ_W:0]    entry_count,
  output logic [ADDR_W-1:0] pos,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  localparam logic [ADDR_W-1:0] POS_MAX    = '1;
  localparam logic [SEQ_W:0]    FULL_COUNT = (SEQ_W+1)'(MAX_ENTRIES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pos_q, pos_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [SEQ_W:0]      entry_count_q, entry_count_d;
  logic [1:0]          err_q, err_d;
  logic [RAM_W-1:0]    desc_q, desc_d;
  logic [ADDR_W-1:0]   pos_next;
  logic                table_full;

  assign pos_next   = pos_q + 1'b1;
  assign table_full = (entry_count_q == FULL_COUNT);

  // Next-state logic: symbol consumption, descriptor latching and write handshake
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    first_d       = first_q;
    seq_d         = seq_q;
    entry_count_d = entry_count_q;
    err_d         = err_q;
    desc_d        = desc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pos_d         = '0;
          first_d       = '0;
          seq_d         = '0;
          entry_count_d = '0;
          err_d         = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (sym_valid) begin
          pos_d = pos_next;
          if (pos_q == POS_MAX) begin
            err_d[1] = 1'b1;
          end
          if (sym_code[1]) begin
            first_d = pos_next;
            if (table_full) begin
              err_d[0] = 1'b1;
              if (sym_code[0]) begin
                state_d = DONE;
              end
            end else begin
              desc_d                              = '0;
              desc_d[0]                           = sym_code[0];
              desc_d[ADDR_W:1]                    = pos_q;
              desc_d[2*ADDR_W:ADDR_W+1]           = first_q;
              desc_d[SEQ_W+2*ADDR_W:2*ADDR_W+1]   = seq_q;
              state_d                             = WRITE;
            end
          end
        end
      end
      WRITE: begin
        if (ram_ready) begin
          seq_d         = seq_q + 1'b1;
          entry_count_d = entry_count_q + 1'b1;
          state_d       = desc_q[0] ? DONE : SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_1KHz) begin
    if (reset) begin
      state_q       <= IDLE;
      pos_q         <= '0;
      first_q       <= '0;
      seq_q         <= '0;
      entry_count_q <= '0;
      err_q         <= '0;
      desc_q        <= '0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      first_q       <= first_d;
      seq_q         <= seq_d;
      entry_count_q <= entry_count_d;
      err_q         <= err_d;
      desc_q        <= desc_d;
    end
  end

  assign sym_ready   = (state_q == SCAN);
  assign ram_we      = (state_q == WRITE);
  assign busy        = (state_q == SCAN) || (state_q == WRITE);
  assign done        = (state_q == DONE);
  assign ram_addr    = seq_q;
  assign ram_data    = desc_q;
  assign entry_count = entry_count_q;
  assign pos         = pos_q;
  assign err         = err_q;

endmodule
